booth_mult_ctrl: RTL and testbench

Issue/capture controller for the radix-2 Booth multiplier. It accepts signed operand pairs over a valid/ready handshake and drives the multiplier's load (active-low reset) and operand inputs. It waits for the multiplier's one-cycle `done` pulse, captures the product, and presents it downstream over a second valid/ready handshake. The multiplier is instantiated beside this block, not inside it.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_mult_ctrl.sv | 129 ++++++++++++
 tb/tb_booth_mult_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding and width helpers for the Booth multiplier controller.
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic int op_width(input int nb);
    return 1 << nb;
  endfunction

  function automatic int cnt_width(input int nb);
    return nb + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: issue/capture controller for an external radix-2 Booth multiplier.
// Optional build macro BOOTH_CTRL_ZERO_BYPASS_EN short-circuits zero operands straight to HOLD.
`default_nettype none

module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int Nb = 2,
  parameter int n  = op_width(Nb),
  parameter int m  = 2 * n
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_m,
  input  logic [n-1:0] in_q,
  output logic         mult_rst,
  output logic [n-1:0] mult_im,
  output logic [n-1:0] mult_iq,
  input  logic         mult_done,
  input  logic [m-1:0] mult_p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [m-1:0] out_p,
  output logic         err
);

  localparam int            CW       = cnt_width(Nb);
  localparam logic [CW-1:0] RUN_LAST = CW'(n);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state, state_nx;
  logic [CW-1:0] run_cnt;
  logic          accept;
  logic          capture;
  logic          bypass;
  logic          protocol_err;
  logic          zero_ops;

`ifdef BOOTH_CTRL_ZERO_BYPASS_EN
  assign zero_ops = (in_m == '0) || (in_q == '0);
`else
  assign zero_ops = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    in_ready     = 1'b0;
    mult_rst     = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    bypass       = 1'b0;
    protocol_err = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          bypass   = zero_ops;
          state_nx = zero_ops ? HOLD : LOAD;
        end
      end
      LOAD: state_nx = RUN;
      RUN: begin
        mult_rst = 1'b1;
        if (mult_done) begin
          // an off-schedule done is flagged but its product is still delivered
          capture      = 1'b1;
          protocol_err = (run_cnt != RUN_LAST);
          state_nx     = HOLD;
        end else if (run_cnt == RUN_LAST) begin
          protocol_err = 1'b1;
          state_nx     = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept   = 1'b1;
            bypass   = zero_ops;
            state_nx = zero_ops ? HOLD : LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cnt   <= '0;
      mult_im   <= '0;
      mult_iq   <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        mult_im <= in_m;
        mult_iq <= in_q;
      end
      if (state == LOAD)     run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + CNT_ONE;
      if (protocol_err) err <= 1'b1;
      if (capture) begin
        out_p     <= mult_p;
        out_valid <= 1'b1;
      end else if (bypass) begin
        out_p     <= '0;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: randomized and directed self-checking bench with a behavioural multiplier beside the DUT.
`default_nettype none

module tb_booth_mult_ctrl;

  localparam int NB  = 2;
  localparam int N   = 4;
  localparam int M   = 8;
  localparam int LAT = N + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_m = '0;
  logic [N-1:0] in_q = '0;
  logic         mult_rst;
  logic [N-1:0] mult_im;
  logic [N-1:0] mult_iq;
  logic         mult_done;
  logic [M-1:0] mult_p;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [M-1:0] out_p;
  logic         err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  booth_mult_ctrl #(.Nb(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_q      (in_q),
    .mult_rst  (mult_rst),
    .mult_im   (mult_im),
    .mult_iq   (mult_iq),
    .mult_done (mult_done),
    .mult_p    (mult_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .err       (err)
  );

  // Behavioural multiplier: loads while its reset is low, pulses done n cycles into the run.
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [M-1:0] m_p = '0;
  logic [N-1:0] m_im = '0;
  logic [N-1:0] m_iq = '0;
  bit           drop_done = 1'b0;
  bit           early_done = 1'b0;

  assign mult_done = m_done;
  assign mult_p    = m_p;

  always @(posedge clk) begin
    if (!mult_rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_im   <= mult_im;
      m_iq   <= mult_iq;
    end else begin
      m_cnt <= m_cnt + 1;
      if (!drop_done && m_cnt == (early_done ? N - 2 : N - 1)) begin
        m_done <= 1'b1;
        m_p    <= 8'(int'($signed(m_im)) * int'($signed(m_iq)));
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  function automatic logic [M-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    int x;
    x = int'($signed(a)) * int'($signed(b));
    return x[M-1:0];
  endfunction

  function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef BOOTH_CTRL_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 1;
`endif
    return LAT;
  endfunction

  // Called at a negedge; returns at the negedge one cycle after the accept edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, output logic rdy);
    in_m     = a;
    in_q     = b;
    in_valid = 1'b1;
    #1 rdy = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts cycles after the accept edge; -1 when out_valid never rose.
  task automatic wait_valid(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++; if (out_p !== 8'h00) begin mismatched++; $display("FAIL reset_out_p: got %h want 00", out_p); end
    compared++; if (mult_rst !== 1'b0) begin mismatched++; $display("FAIL reset_mult_rst: got %b want 0", mult_rst); end
    compared++; if ({mult_im, mult_iq} !== 8'h00) begin mismatched++; $display("FAIL reset_operands: got %h want 00", {mult_im, mult_iq}); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b1;
    @(negedge clk);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [3];
    logic [N-1:0] tq [3];
    logic [M-1:0] te [3];
    logic         rdy;
    int           lat;
    ta = '{4'd3, 4'hD, 4'h8};
    tq = '{4'd5, 4'd5, 4'h8};
    te = '{8'h0F, 8'hF1, 8'h40};
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tq[i], rdy);
      compared++; if (rdy !== 1'b1) begin mismatched++; $display("FAIL dir%0d_in_ready: got %b want 1", i, rdy); end
      wait_valid(20, lat);
      compared++; if (lat != LAT) begin mismatched++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
      compared++; if (out_p !== te[i]) begin mismatched++; $display("FAIL dir%0d_out_p: got %h want %h", i, out_p, te[i]); end
      compared++; if ({mult_im, mult_iq} !== {ta[i], tq[i]}) begin mismatched++; $display("FAIL dir%0d_operands: got %h want %h", i, {mult_im, mult_iq}, {ta[i], tq[i]}); end
      compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL dir%0d_err: got %b want 0", i, err); end
      drain();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL dir%0d_drain: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    logic [M-1:0] exp_p;
    logic         rdy;
    int           lat, hold;
    bit           stable;
    for (int i = 0; i < 16; i++) begin
      a     = N'($urandom);
      b     = N'($urandom);
      exp_p = ref_prod(a, b);
      hold  = $urandom_range(0, 3);
      issue(a, b, rdy);
      compared++; if (rdy !== 1'b1) begin mismatched++; $display("FAIL rnd%0d_in_ready: got %b want 1", i, rdy); end
      wait_valid(20, lat);
      compared++; if (lat != ref_lat(a, b)) begin mismatched++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, ref_lat(a, b)); end
      compared++; if (out_p !== exp_p) begin mismatched++; $display("FAIL rnd%0d_out_p %h*%h: got %h want %h", i, a, b, out_p, exp_p); end
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_p !== exp_p) stable = 1'b0;
      end
      compared++; if (!stable) begin mismatched++; $display("FAIL rnd%0d_hold_stable: got %h/%b want %h/1", i, out_p, out_valid, exp_p); end
      compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL rnd%0d_err: got %b want 0", i, err); end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b;
    logic         rdy;
    int           lat, lows;
    a = N'($urandom_range(1, 7));
    b = N'($urandom_range(9, 15));
    issue(a, b, rdy);
    wait_valid(20, lat);
    compared++; if (lat != LAT) begin mismatched++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
    compared++; if (out_p !== ref_prod(a, b)) begin mismatched++; $display("FAIL b2b_first_out_p: got %h want %h", out_p, ref_prod(a, b)); end
    out_ready = 1'b1;
    a = N'($urandom_range(9, 15));
    b = N'($urandom_range(9, 15));
    issue(a, b, rdy);
    compared++; if (rdy !== 1'b1) begin mismatched++; $display("FAIL b2b_accept_in_hold: got %b want 1", rdy); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
    lows = 0;
    lat  = -1;
    for (int k = 1; k <= 20; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (mult_rst === 1'b0) lows++;
      @(negedge clk);
    end
    compared++; if (lat != LAT) begin mismatched++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT); end
    compared++; if (lows != 1) begin mismatched++; $display("FAIL b2b_load_cycles: got %0d want 1", lows); end
    compared++; if (out_p !== ref_prod(a, b)) begin mismatched++; $display("FAIL b2b_second_out_p: got %h want %h", out_p, ref_prod(a, b)); end
    @(negedge clk);
    out_ready = 1'b0;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_final_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic rdy;
    int   lat;
    issue(4'd7, 4'hE, rdy);
    wait_valid(20, lat);
    compared++; if (lat != LAT) begin mismatched++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    in_m     = 4'd1;
    in_q     = 4'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      compared++;
      if ({out_valid, out_p, in_ready, mult_rst} !== {1'b1, 8'hF2, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got valid=%b p=%h ready=%b mrst=%b want 1/f2/0/0", i, out_valid, out_p, in_ready, mult_rst);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    compared++; if ({out_valid, in_ready} !== 2'b01) begin mismatched++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    logic rdy;
    int   lat;
    bit   seen;
    issue(4'd3, 4'd3, rdy);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    compared++; if ({out_valid, mult_rst} !== 2'b00) begin mismatched++; $display("FAIL midrst_state: got valid=%b mrst=%b want 0/0", out_valid, mult_rst); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_release_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    compared++; if (seen) begin mismatched++; $display("FAIL midrst_no_output: got out_valid=1 want 0"); end
    issue(4'd2, 4'd2, rdy);
    wait_valid(20, lat);
    compared++; if (lat != LAT || out_p !== 8'h04) begin mismatched++; $display("FAIL midrst_next_op: got lat=%0d p=%h want %0d/04", lat, out_p, LAT); end
    drain();
  endtask

  task automatic test_zero();
    logic rdy;
    int   lat, highs;
    issue(4'd0, 4'h9, rdy);
    highs = 0;
    lat   = -1;
    for (int k = 1; k <= 20; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (mult_rst === 1'b1) highs++;
      @(negedge clk);
    end
    compared++; if (out_p !== 8'h00) begin mismatched++; $display("FAIL zero_out_p: got %h want 00", out_p); end
`ifdef BOOTH_CTRL_ZERO_BYPASS_EN
    compared++; if (lat != 1) begin mismatched++; $display("FAIL zero_latency: got %0d want 1", lat); end
    compared++; if (highs != 0) begin mismatched++; $display("FAIL zero_mult_rst_high: got %0d want 0", highs); end
`else
    compared++; if (lat != LAT) begin mismatched++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
    compared++; if (highs != N + 1) begin mismatched++; $display("FAIL zero_run_cycles: got %0d want %0d", highs, N + 1); end
`endif
    drain();
  endtask

  task automatic test_bad_done();
    logic rdy;
    int   lat;
    bit   seen;
    drop_done = 1'b1;
    issue(4'd1, 4'd1, rdy);
    seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      if (k == LAT - 1) begin
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL drop_err_early: got %b want 0", err); end
      end
      if (k == LAT) begin
        compared++; if ({err, in_ready} !== 2'b11) begin mismatched++; $display("FAIL drop_err_idle: got err=%b ready=%b want 1/1", err, in_ready); end
      end
      @(negedge clk);
    end
    drop_done = 1'b0;
    compared++; if (seen) begin mismatched++; $display("FAIL drop_no_output: got out_valid=1 want 0"); end
    issue(4'd2, 4'd3, rdy);
    wait_valid(20, lat);
    compared++; if (lat != LAT || out_p !== 8'h06 || err !== 1'b1) begin mismatched++; $display("FAIL drop_sticky: got lat=%0d p=%h err=%b want %0d/06/1", lat, out_p, err, LAT); end
    drain();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL err_reset_clear: got %b want 0", err); end
    @(negedge clk);
    early_done = 1'b1;
    issue(4'd3, 4'hF, rdy);
    wait_valid(20, lat);
    early_done = 1'b0;
    compared++; if (lat != LAT - 1 || out_p !== 8'hFD) begin mismatched++; $display("FAIL early_capture: got lat=%0d p=%h want %0d/fd", lat, out_p, LAT - 1); end
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL early_err: got %b want 1", err); end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_zero();
    test_bad_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
